// File: rtl/emissor_instrucoes_pkg.sv
// Shared definitions for the matrix coprocessor instruction path.
// Holds the instruction width, the field positions and the issue FSM states.
package pkg_coprocessador;

  localparam int LARG_INSTR = 28;

  // Instruction field positions: opcode | linha | coluna | dado | id_matriz
  localparam int OPCODE_MSB = 27;
  localparam int OPCODE_LSB = 24;
  localparam int LINHA_MSB  = 23;
  localparam int LINHA_LSB  = 21;
  localparam int COLUNA_MSB = 20;
  localparam int COLUNA_LSB = 18;
  localparam int DADO_MSB   = 17;
  localparam int DADO_LSB   = 2;
  localparam int ID_MSB     = 1;
  localparam int ID_LSB     = 0;

  typedef logic [LARG_INSTR-1:0] instr_t;

  typedef enum logic {
    OCIOSO = 1'b0,
    ESPERA = 1'b1
  } estado_emissor_t;

endpackage

// File: rtl/emissor_instrucoes_if.sv
// Bundle between the host, the issue stage and the coprocessor.
// master = host/bench side, slave = the issue stage itself.
interface emissor_instrucoes_if #(
  parameter int PROF = 8
);
  import pkg_coprocessador::*;

  instr_t               instr_in;
  logic                 instr_valid;
  logic                 instr_ready;
  logic                 limpar;
  instr_t               instrucao;
  logic                 start_instr;
  logic [$clog2(PROF):0] nivel;
  logic                 ocioso;
  logic                 erro_overflow;

  modport master (
    output instr_in, instr_valid, limpar,
    input  instr_ready, instrucao, start_instr, nivel, ocioso, erro_overflow
  );

  modport slave (
    input  instr_in, instr_valid, limpar,
    output instr_ready, instrucao, start_instr, nivel, ocioso, erro_overflow
  );

endinterface

// File: rtl/emissor_instrucoes_fifo.sv
// Circular instruction buffer. Pointers wrap naturally because PROF is a
// power of two; nivel carries one extra bit so it can represent "full".
module fifo_instrucoes #(
  parameter int PROF = 8,
  parameter int LARG = 28
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  limpar,
  input  logic                  push,
  input  logic                  pop,
  input  logic [LARG-1:0]       dados_in,
  output logic [LARG-1:0]       dados_out,
  output logic [$clog2(PROF):0] nivel,
  output logic                  cheio,
  output logic                  vazio
);
  localparam int PW = $clog2(PROF);
  localparam logic [PW:0] NIVEL_CHEIO = (PW+1)'(PROF);

  logic [LARG-1:0] mem [PROF];
  logic [PW-1:0]   ptr_esc;
  logic [PW-1:0]   ptr_leit;
  logic            push_ef;
  logic            pop_ef;

  assign cheio     = (nivel == NIVEL_CHEIO);
  assign vazio     = (nivel == '0);
  assign push_ef   = push && !cheio && !limpar;
  assign pop_ef    = pop && !vazio && !limpar;
  assign dados_out = mem[ptr_leit];

  // Pointers and occupancy; a flush wins over any push or pop on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_esc  <= '0;
      ptr_leit <= '0;
      nivel    <= '0;
    end else if (limpar) begin
      ptr_esc  <= '0;
      ptr_leit <= '0;
      nivel    <= '0;
    end else begin
      if (push_ef) ptr_esc <= ptr_esc + 1'b1;
      if (pop_ef) ptr_leit <= ptr_leit + 1'b1;
      if (push_ef && !pop_ef) nivel <= nivel + 1'b1;
      else if (!push_ef && pop_ef) nivel <= nivel - 1'b1;
    end
  end

  // Storage array, written only on an accepted push (no reset needed)
  always_ff @(posedge clk) begin
    if (push_ef) mem[ptr_esc] <= dados_in;
  end

endmodule

// File: rtl/emissor_instrucoes.sv
// Instruction issue stage: buffers host instructions and issues them one at
// a time with a start pulse, keeping a fixed minimum spacing because the
// coprocessor gives no completion feedback.
module emissor_instrucoes
  import pkg_coprocessador::*;
#(
  parameter int PROF      = 8,
  parameter int INTERVALO = 4
) (
  input logic                 clk,
  input logic                 reset,
  emissor_instrucoes_if.slave bus
);
  localparam int CW = $clog2(INTERVALO) + 1;
  localparam logic [CW-1:0] CNT_CARGA = CW'(INTERVALO - 1);
  localparam logic [CW-1:0] CNT_FIM   = CW'(1);

  estado_emissor_t       estado;
  estado_emissor_t       estado_prox;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_prox;
  logic                  pop;
  logic                  start_prox;
  logic                  cheio;
  logic                  vazio;
  logic [$clog2(PROF):0] nivel;
  instr_t                cabeca;
  instr_t                instrucao_q;
  logic                  start_q;
  logic                  overflow_q;

  fifo_instrucoes #(
    .PROF(PROF),
    .LARG(LARG_INSTR)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .limpar   (bus.limpar),
    .push     (bus.instr_valid),
    .pop      (pop),
    .dados_in (bus.instr_in),
    .dados_out(cabeca),
    .nivel    (nivel),
    .cheio    (cheio),
    .vazio    (vazio)
  );

  // Next-state logic: issue from OCIOSO when data is waiting, then count down the spacing window
  always_comb begin
    estado_prox = estado;
    cnt_prox    = cnt;
    pop         = 1'b0;
    start_prox  = 1'b0;
    if (bus.limpar) begin
      estado_prox = OCIOSO;
      cnt_prox    = '0;
    end else begin
      unique case (estado)
        OCIOSO: begin
          if (!vazio) begin
            pop         = 1'b1;
            start_prox  = 1'b1;
            cnt_prox    = CNT_CARGA;
            estado_prox = ESPERA;
          end
        end
        ESPERA: begin
          cnt_prox = cnt - 1'b1;
          if (cnt == CNT_FIM) estado_prox = OCIOSO;
        end
        default: estado_prox = OCIOSO;
      endcase
    end
  end

  // State, spacing counter and registered issue outputs; instrucao only moves on an issue
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado      <= OCIOSO;
      cnt         <= '0;
      start_q     <= 1'b0;
      instrucao_q <= '0;
    end else begin
      estado  <= estado_prox;
      cnt     <= cnt_prox;
      start_q <= start_prox;
      if (pop) instrucao_q <= cabeca;
    end
  end

  // Sticky overflow flag; a push offered together with a flush is not an overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (bus.limpar) begin
      overflow_q <= 1'b0;
    end else if (bus.instr_valid && cheio) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.instr_ready   = !cheio;
  assign bus.nivel         = nivel;
  assign bus.ocioso        = vazio && (estado == OCIOSO);
  assign bus.instrucao     = instrucao_q;
  assign bus.start_instr   = start_q;
  assign bus.erro_overflow = overflow_q;

endmodule

// File: tb/tb_emissor_instrucoes.sv
// Self-checking bench for emissor_instrucoes: a cycle model tracks the
// expected FIFO contents and issue pulses, a scoreboard checks issue order,
// and a vector table drives burst patterns.
module tb_emissor_instrucoes;
  import pkg_coprocessador::*;

  localparam int PROF      = 8;
  localparam int INTERVALO = 4;

  logic clk;
  logic reset;

  emissor_instrucoes_if #(.PROF(PROF)) bus ();

  emissor_instrucoes #(
    .PROF     (PROF),
    .INTERVALO(INTERVALO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int peak   = 0;

  // Reference model state
  instr_t m_fifo[$];
  instr_t sb_q[$];
  bit     m_est   = 1'b0;
  int     m_cnt   = 0;
  bit     m_start = 1'b0;
  instr_t m_instr = '0;
  bit     m_ovf   = 1'b0;

  typedef struct {
    int     n;
    instr_t base;
    int     gap;
    int     exp_peak;
    bit     exp_ovf;
  } vec_t;

  vec_t vecs[5];

  task automatic check_output(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle model: evaluates every edge with the inputs held since the last edge
  initial begin
    bit full;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_fifo.delete(); sb_q.delete();
        m_est = 0; m_cnt = 0; m_start = 0; m_instr = '0; m_ovf = 0;
      end else if (bus.limpar) begin
        m_fifo.delete(); sb_q.delete();
        m_est = 0; m_cnt = 0; m_start = 0; m_ovf = 0;
      end else begin
        full = (m_fifo.size() == PROF);
        if (bus.instr_valid && full) m_ovf = 1;
        if (m_est == 0) begin
          if (m_fifo.size() > 0) begin
            m_instr = m_fifo.pop_front();
            m_start = 1;
            m_cnt   = INTERVALO - 1;
            m_est   = 1;
          end else begin
            m_start = 0;
          end
        end else begin
          m_start = 0;
          if (m_cnt == 1) m_est = 0;
          m_cnt--;
        end
        if (bus.instr_valid && !full) begin
          m_fifo.push_back(bus.instr_in);
          sb_q.push_back(bus.instr_in);
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus scoreboard pop on each issue pulse
  initial begin
    instr_t exp_i;
    forever begin
      @(negedge clk);
      check_output("start_instr", 32'(bus.start_instr), 32'(m_start));
      check_output("nivel", 32'(bus.nivel), 32'(m_fifo.size()));
      check_output("instr_ready", 32'(bus.instr_ready), 32'(m_fifo.size() != PROF));
      check_output("ocioso", 32'(bus.ocioso), 32'(m_fifo.size() == 0 && m_est == 0));
      check_output("erro_overflow", 32'(bus.erro_overflow), 32'(m_ovf));
      check_output("instrucao", 32'(bus.instrucao), 32'(m_instr));
      if (bus.start_instr) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL issue_order: got pulse with %0h, required no pulse (queue empty)", bus.instrucao);
        end else begin
          exp_i = sb_q.pop_front();
          check_output("issue_order", 32'(bus.instrucao), 32'(exp_i));
        end
      end
    end
  end

  task automatic apply_stimulus(input int n, input instr_t base, input int gap);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.instr_valid = 1'b1;
      bus.instr_in    = base + 28'(i) * 28'h0123457;
      @(negedge clk);
      if (int'(bus.nivel) > peak) peak = int'(bus.nivel);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(negedge clk);
        if (int'(bus.nivel) > peak) peak = int'(bus.nivel);
      end
    end
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (int'(bus.nivel) > peak) peak = int'(bus.nivel);
      if (bus.ocioso) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got ocioso=0 after 300 cycles, required 1");
    end
  endtask

  task automatic pulse_limpar();
    @(posedge clk); #1;
    bus.limpar = 1'b1;
    @(posedge clk); #1;
    bus.limpar = 1'b0;
  endtask

  initial begin
    int pulses;
    bit seen;
    instr_t held;

    vecs[0] = '{n: 1,  base: 28'h1234567, gap: 0, exp_peak: 1, exp_ovf: 1'b0};
    vecs[1] = '{n: 5,  base: 28'hA000001, gap: 0, exp_peak: 4, exp_ovf: 1'b0};
    vecs[2] = '{n: 20, base: 28'h0F0F0F0, gap: 3, exp_peak: 1, exp_ovf: 1'b0};
    vecs[3] = '{n: 16, base: 28'h5500AA0, gap: 0, exp_peak: 8, exp_ovf: 1'b1};
    vecs[4] = '{n: 8,  base: 28'h3C3C3C3, gap: 1, exp_peak: 4, exp_ovf: 1'b0};

    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_in    = '0;
    bus.limpar      = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check_output("rst_nivel", 32'(bus.nivel), 32'd0);
    check_output("rst_ready", 32'(bus.instr_ready), 32'd1);
    check_output("rst_ocioso", 32'(bus.ocioso), 32'd1);
    check_output("rst_start", 32'(bus.start_instr), 32'd0);
    check_output("rst_instrucao", 32'(bus.instrucao), 32'd0);
    check_output("rst_overflow", 32'(bus.erro_overflow), 32'd0);

    // Vector table: bursts of pushes with varying gaps
    for (int v = 0; v < 5; v++) begin
      peak = 0;
      apply_stimulus(vecs[v].n, vecs[v].base, vecs[v].gap);
      wait_drain();
      check_output($sformatf("peak_nivel_v%0d", v), 32'(peak), 32'(vecs[v].exp_peak));
      check_output($sformatf("overflow_v%0d", v), 32'(bus.erro_overflow), 32'(vecs[v].exp_ovf));
      pulse_limpar();
      @(negedge clk);
      check_output($sformatf("overflow_clr_v%0d", v), 32'(bus.erro_overflow), 32'd0);
    end

    // Flush while full and in overflow, with a push offered on the flush edge
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      bus.instr_valid = 1'b1;
      bus.instr_in    = 28'h7700000 + 28'(i);
    end
    @(posedge clk); #1;
    bus.limpar   = 1'b1;
    bus.instr_in = 28'h7FFFFFF;
    held         = m_instr;
    @(posedge clk); #1;
    bus.limpar      = 1'b0;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    check_output("flush_nivel", 32'(bus.nivel), 32'd0);
    check_output("flush_overflow", 32'(bus.erro_overflow), 32'd0);
    check_output("flush_instrucao", 32'(bus.instrucao), 32'(held));
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.start_instr) pulses++;
    end
    check_output("flush_no_pulses", 32'(pulses), 32'd0);

    // Asynchronous reset asserted in the middle of an issue pulse
    apply_stimulus(1, 28'h0ABCDEF, 0);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.start_instr) seen = 1;
    end
    check_output("async_pulse_seen", 32'(seen), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_output("async_start", 32'(bus.start_instr), 32'd0);
    check_output("async_nivel", 32'(bus.nivel), 32'd0);
    check_output("async_ocioso", 32'(bus.ocioso), 32'd1);
    check_output("async_instrucao", 32'(bus.instrucao), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Recovery after reset
    peak = 0;
    apply_stimulus(3, 28'h0C0FFEE, 0);
    wait_drain();
    check_output("recover_peak", 32'(peak), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
